// File: rtl/sprint_timer_pkg.sv
// Shared types and constants for the sprint timer slice.
// State enum, BCD digit geometry and the saturation value.
package sprint_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP,
    FULL
  } state_t;

  localparam int C_DIG_W   = 4;
  localparam int C_NUM_DIG = 4;

  localparam logic [15:0] C_MAX_BCD = 16'h9999;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the elapsed-time counter (0..9 with carry out).
// Ports: clk, rst (sync, high), clr, inc in; digit, carry out.
module bcd_digit_cnt
  import sprint_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [C_DIG_W-1:0] digit,
  output logic               carry
);

  logic at_nine;

  assign at_nine = (digit == C_DIG_W'(9));
  assign carry   = inc & at_nine;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= at_nine ? '0 : digit + 1'b1;
    end
  end

endmodule

// File: rtl/sprint_timer_ctrl.sv
// Sprint timer control: key edges, 4-state FSM, 100 Hz prescaler,
// SS.cc BCD count. Ports: I_clk, I_rst (sync, high), I_start_key,
// I_clr_key, [I_lap_key], O_digits, O_running, O_ovf.
// Optional lap display enabled by macro SPRINT_LAP_EN.
module sprint_timer_ctrl
  import sprint_timer_pkg::*;
#(
  parameter int C_TICK_DIV = 1000000,
  parameter int C_CNT_W    = 20
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_start_key,
  input  logic        I_clr_key,
`ifdef SPRINT_LAP_EN
  input  logic        I_lap_key,
`endif
  output logic [15:0] O_digits,
  output logic        O_running,
  output logic        O_ovf
);

  state_t state;

  logic start_d;
  logic clr_d;
  logic hist_vld;
  logic start_rise;
  logic clr_rise;

  logic [C_CNT_W-1:0] presc;
  logic               tick;

  logic [15:0] live;
  logic        at_max;
  logic        cnt_inc;
  logic        cnt_clr;

  logic [C_DIG_W-1:0] dig [C_NUM_DIG];
  logic [C_NUM_DIG:0] inc_c;
  logic               unused_carry;

  // History is cleared by reset; edges are only accepted once
  // history holds a real post-reset sample, so a key held through
  // reset release does not count as a press.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      start_d  <= 1'b0;
      clr_d    <= 1'b0;
      hist_vld <= 1'b0;
    end else begin
      start_d  <= I_start_key;
      clr_d    <= I_clr_key;
      hist_vld <= 1'b1;
    end
  end

  assign start_rise = I_start_key & ~start_d & hist_vld;
  assign clr_rise   = I_clr_key & ~clr_d & hist_vld;

  // Held at zero outside RUN, so every RUN entry starts fresh.
  assign tick = (state == RUN) &&
                (presc == C_CNT_W'(C_TICK_DIV - 1));

  always_ff @(posedge I_clk) begin
    if (I_rst || (state != RUN) || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign live   = {dig[3], dig[2], dig[1], dig[0]};
  assign at_max = (live == C_MAX_BCD);

  // Stop wins over a coincident tick; 99.99 saturates.
  assign cnt_inc = tick & ~start_rise & ~at_max;
  assign cnt_clr = clr_rise &
                   ((state == STOP) || (state == FULL));

  assign inc_c[0] = cnt_inc;

  for (genvar i = 0; i < C_NUM_DIG; i++) begin : g_dig
    bcd_digit_cnt u_dig (
      .clk   (I_clk),
      .rst   (I_rst),
      .clr   (cnt_clr),
      .inc   (inc_c[i]),
      .digit (dig[i]),
      .carry (inc_c[i+1])
    );
  end

  assign unused_carry = inc_c[C_NUM_DIG];

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state     <= IDLE;
      O_running <= 1'b0;
      O_ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_rise) begin
            state     <= RUN;
            O_running <= 1'b1;
          end
        end
        RUN: begin
          if (start_rise) begin
            state     <= STOP;
            O_running <= 1'b0;
          end else if (tick && at_max) begin
            state     <= FULL;
            O_running <= 1'b0;
            O_ovf     <= 1'b1;
          end
        end
        STOP: begin
          if (clr_rise) begin
            state <= IDLE;
          end else if (start_rise) begin
            state     <= RUN;
            O_running <= 1'b1;
          end
        end
        FULL: begin
          if (clr_rise) begin
            state <= IDLE;
            O_ovf <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          O_running <= 1'b0;
          O_ovf     <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPRINT_LAP_EN
  logic        lap_d;
  logic        lap_rise;
  logic        lap;
  logic [15:0] snap;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      lap_d <= 1'b0;
    end else begin
      lap_d <= I_lap_key;
    end
  end

  assign lap_rise = I_lap_key & ~lap_d & hist_vld;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      lap  <= 1'b0;
      snap <= '0;
    end else if (state != RUN) begin
      lap <= 1'b0;
    end else if (start_rise || (tick && at_max)) begin
      lap <= 1'b0;
    end else if (lap_rise) begin
      if (!lap) begin
        snap <= live;
        lap  <= 1'b1;
      end else begin
        lap <= 1'b0;
      end
    end
  end

  assign O_digits = lap ? snap : live;
`else
  assign O_digits = live;
`endif

endmodule
